// File: rtl/o8_wide_seq_if.sv
// Request/result handshake and 8-bit ALU side-channel for the o8_wide_seq sequencer.
// The slave modport is the sequencer. The master modport is its environment.
interface o8_wide_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        req_cin;
    logic        req_sub;

    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_zf;
    logic        res_cf;
    logic        res_of;
    logic        res_sf;

    logic [2:0]  alu_op;
    logic [7:0]  alu_left;
    logic [7:0]  alu_right;
    logic        alu_cf_in;
    logic        alu_not_left;
    logic        alu_not_right;
    logic        alu_not_result;
    logic [7:0]  alu_result;
    logic        alu_cf_out;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_cin, req_sub,
        input  res_ready, alu_result, alu_cf_out,
        output req_ready, res_valid, res_data, res_zf, res_cf, res_of, res_sf,
        output alu_op, alu_left, alu_right, alu_cf_in,
        output alu_not_left, alu_not_right, alu_not_result
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_cin, req_sub,
        output res_ready, alu_result, alu_cf_out,
        input  req_ready, res_valid, res_data, res_zf, res_cf, res_of, res_sf,
        input  alu_op, alu_left, alu_right, alu_cf_in,
        input  alu_not_left, alu_not_right, alu_not_result
    );
endinterface

// File: rtl/o8_wide_seq.sv
// 16-bit operation sequenced through an external 8-bit ALU, low byte then high byte.
// Produces a 16-bit result with zero, carry, overflow and sign flags.
module o8_wide_seq (
    input  logic         clk,
    input  logic         reset,
    o8_wide_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] OP_LEFT = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SHRL = 3'd5;
    localparam logic [2:0] OP_RSV6 = 3'd6;
    localparam logic [2:0] OP_RSV7 = 3'd7;

    state_t      state_r;
    logic [2:0]  op_r;
    logic [7:0]  a_hi_r;
    logic [7:0]  b_hi_r;
    logic        a0_r;
    logic        sub_r;
    logic [7:0]  lo_byte_r;

    logic [2:0]  alu_op_r;
    logic [7:0]  alu_left_r;
    logic [7:0]  alu_right_r;
    logic        alu_cf_in_r;
    logic        alu_not_right_r;

    logic [15:0] res_data_r;
    logic        res_zf_r;
    logic        res_cf_r;
    logic        res_of_r;
    logic        res_sf_r;

    logic [15:0] data_s;
    logic        cf_s;
    logic        of_s;
    logic        zf_s;
    logic        sf_s;
    logic        b_eff_msb_s;

    // Assemble the 16-bit result from the stored low byte and the high byte the ALU returns in HI.
    always_comb begin
        b_eff_msb_s = sub_r ? ~b_hi_r[7] : b_hi_r[7];
        data_s      = {bus.alu_result, lo_byte_r};
        cf_s        = 1'b0;
        of_s        = 1'b0;
        case (op_r)
            OP_ADD: begin
                cf_s = bus.alu_cf_out;
                of_s = (a_hi_r[7] == b_eff_msb_s) && (bus.alu_result[7] != a_hi_r[7]);
            end
            OP_SHRL: begin
                // The per-byte shift loses a[8]; put it back as bit 7 of the low byte.
                data_s = {bus.alu_result, lo_byte_r | {a_hi_r[0], 7'd0}};
                cf_s   = a0_r;
            end
            OP_RSV6, OP_RSV7: begin
                data_s = 16'h0000;
            end
            default: begin
                data_s = {bus.alu_result, lo_byte_r};
            end
        endcase
        zf_s = (data_s == 16'h0000);
        sf_s = data_s[15];
    end

    // Sequencer FSM. ALU drive values are preloaded one edge ahead so that every output comes from a register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= IDLE;
            op_r            <= 3'd0;
            a_hi_r          <= 8'd0;
            b_hi_r          <= 8'd0;
            a0_r            <= 1'b0;
            sub_r           <= 1'b0;
            lo_byte_r       <= 8'd0;
            alu_op_r        <= 3'd0;
            alu_left_r      <= 8'd0;
            alu_right_r     <= 8'd0;
            alu_cf_in_r     <= 1'b0;
            alu_not_right_r <= 1'b0;
            res_data_r      <= 16'h0000;
            res_zf_r        <= 1'b0;
            res_cf_r        <= 1'b0;
            res_of_r        <= 1'b0;
            res_sf_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req_valid) begin
                        state_r         <= LO;
                        op_r            <= bus.req_op;
                        a_hi_r          <= bus.req_a[15:8];
                        b_hi_r          <= bus.req_b[15:8];
                        a0_r            <= bus.req_a[0];
                        sub_r           <= bus.req_sub;
                        alu_op_r        <= (bus.req_op > OP_SHRL) ? OP_LEFT : bus.req_op;
                        alu_left_r      <= bus.req_a[7:0];
                        alu_right_r     <= bus.req_b[7:0];
                        alu_cf_in_r     <= bus.req_cin;
                        alu_not_right_r <= (bus.req_op == OP_ADD) && bus.req_sub;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LO: begin
                    // alu_cf_in_r doubles as the chain-carry register while in HI.
                    state_r     <= HI;
                    lo_byte_r   <= bus.alu_result;
                    alu_left_r  <= a_hi_r;
                    alu_right_r <= b_hi_r;
                    alu_cf_in_r <= bus.alu_cf_out;
                end
                HI: begin
                    // The high byte and high carry land directly in the result registers.
                    state_r         <= DONE;
                    res_data_r      <= data_s;
                    res_zf_r        <= zf_s;
                    res_cf_r        <= cf_s;
                    res_of_r        <= of_s;
                    res_sf_r        <= sf_s;
                    alu_op_r        <= 3'd0;
                    alu_left_r      <= 8'd0;
                    alu_right_r     <= 8'd0;
                    alu_cf_in_r     <= 1'b0;
                    alu_not_right_r <= 1'b0;
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state_r    <= IDLE;
                        res_data_r <= 16'h0000;
                        res_zf_r   <= 1'b0;
                        res_cf_r   <= 1'b0;
                        res_of_r   <= 1'b0;
                        res_sf_r   <= 1'b0;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready      = (state_r == IDLE);
    assign bus.res_valid      = (state_r == DONE);
    assign bus.res_data       = res_data_r;
    assign bus.res_zf         = res_zf_r;
    assign bus.res_cf         = res_cf_r;
    assign bus.res_of         = res_of_r;
    assign bus.res_sf         = res_sf_r;
    assign bus.alu_op         = alu_op_r;
    assign bus.alu_left       = alu_left_r;
    assign bus.alu_right      = alu_right_r;
    assign bus.alu_cf_in      = alu_cf_in_r;
    assign bus.alu_not_left   = 1'b0;
    assign bus.alu_not_right  = alu_not_right_r;
    assign bus.alu_not_result = 1'b0;
endmodule

// File: tb/tb_o8_wide_seq.sv
// Bench for o8_wide_seq: an 8-bit ALU model, a word-level reference, and a per-cycle comparator.
// Directed vectors carry hand-computed results.
module tb_o8_wide_seq;
    logic clk;
    logic reset;
    o8_wide_seq_if bus ();

    o8_wide_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int edge_cnt = 0;

    // Behavioural 8-bit ALU that the sequencer drives.
    logic [7:0] alu_l, alu_r, alu_y;
    logic       alu_c;
    always_comb begin
        alu_l = bus.alu_not_left  ? ~bus.alu_left  : bus.alu_left;
        alu_r = bus.alu_not_right ? ~bus.alu_right : bus.alu_right;
        alu_y = 8'd0;
        alu_c = 1'b0;
        case (bus.alu_op)
            3'd0: alu_y = alu_l;
            3'd1: alu_y = alu_r;
            3'd2: {alu_c, alu_y} = {1'b0, alu_l} + {1'b0, alu_r} + {8'd0, bus.alu_cf_in};
            3'd3: alu_y = alu_l & alu_r;
            3'd4: alu_y = alu_l ^ alu_r;
            3'd5: begin alu_y = alu_l >> 1; alu_c = alu_l[0]; end
            default: alu_y = 8'd0;
        endcase
        if (bus.alu_not_result) alu_y = ~alu_y;
        else                    alu_y = alu_y;
    end
    assign bus.alu_result = alu_y;
    assign bus.alu_cf_out = alu_c;

    // Word-level reference: {data, zf, cf, of, sf}.
    function automatic logic [19:0] model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        logic [15:0] beff, d;
        logic [16:0] s;
        logic cf, of;
        beff = sub ? ~b : b;
        d = 16'd0; cf = 1'b0; of = 1'b0;
        case (op)
            3'd0: d = a;
            3'd1: d = b;
            3'd2: begin
                s = {1'b0, a} + {1'b0, beff} + {16'd0, cin};
                d = s[15:0]; cf = s[16];
                of = (a[15] == beff[15]) && (d[15] != a[15]);
            end
            3'd3: d = a & b;
            3'd4: d = a ^ b;
            3'd5: begin d = a >> 1; cf = a[0]; end
            default: d = 16'd0;
        endcase
        return {d, (d == 16'd0), cf, of, d[15]};
    endfunction

    // Carry the ALU hands from the low byte into the high byte.
    function automatic logic hi_cin(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                    input logic cin, input logic sub);
        logic [15:0] beff;
        logic [8:0]  s;
        beff = sub ? ~b : b;
        s = {1'b0, a[7:0]} + {1'b0, beff[7:0]} + {8'd0, cin};
        if (op == 3'd2)      return s[8];
        else if (op == 3'd5) return a[0];
        else                 return 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Outstanding operation tracked by the comparator.
    logic        pending = 1'b0;
    int          acc_edge = 0;
    logic [2:0]  p_op;
    logic [15:0] p_a, p_b;
    logic        p_cin, p_sub;
    logic [19:0] p_exp;

    // Per-cycle comparison against the reference, then prediction of the coming edge.
    always @(negedge clk) begin
        int age;
        logic [2:0]  e_aop;
        logic [19:0] e_res;
        logic [22:0] e_alu;
        if (edge_cnt >= 1) begin
            age   = pending ? (edge_cnt - acc_edge) : -1;
            e_aop = (p_op > 3'd5) ? 3'd0 : p_op;
            e_res = (pending && age >= 2) ? p_exp : 20'd0;
            if (pending && age == 0)
                e_alu = {e_aop, p_a[7:0], p_b[7:0], p_cin, 1'b0, (p_op == 3'd2) && p_sub, 1'b0};
            else if (pending && age == 1)
                e_alu = {e_aop, p_a[15:8], p_b[15:8], hi_cin(p_op, p_a, p_b, p_cin, p_sub),
                         1'b0, (p_op == 3'd2) && p_sub, 1'b0};
            else
                e_alu = 23'd0;
            check("req_ready", {31'd0, bus.req_ready}, {31'd0, !pending});
            check("res_valid", {31'd0, bus.res_valid}, {31'd0, pending && age >= 2});
            check("res_word", {12'd0, bus.res_data, bus.res_zf, bus.res_cf, bus.res_of, bus.res_sf},
                  {12'd0, e_res});
            check("alu_drive", {9'd0, bus.alu_op, bus.alu_left, bus.alu_right, bus.alu_cf_in,
                  bus.alu_not_left, bus.alu_not_right, bus.alu_not_result}, {9'd0, e_alu});
            if (reset) begin
                pending = 1'b0;
            end else if (!pending && bus.req_valid) begin
                pending = 1'b1; acc_edge = edge_cnt + 1;
                p_op = bus.req_op; p_a = bus.req_a; p_b = bus.req_b;
                p_cin = bus.req_cin; p_sub = bus.req_sub;
                p_exp = model(p_op, p_a, p_b, p_cin, p_sub);
            end else if (pending && age >= 2 && bus.res_ready) begin
                pending = 1'b0;
            end
        end
    end

    task automatic run_op(input string name, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input logic [15:0] e_data,
                          input logic [3:0] e_flags, input int hold);
        int lat;
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b;
        bus.req_cin = cin; bus.req_sub = sub;
        @(posedge clk); #1;
        bus.req_valid = 1'b0; bus.req_a = 16'hDEAD; bus.req_b = 16'hBEEF; bus.req_op = 3'd4;
        lat = 1;
        while (!bus.res_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, lat, 32'd3);
        check({name, "_data"}, {16'd0, bus.res_data}, {16'd0, e_data});
        check({name, "_flags"}, {28'd0, bus.res_zf, bus.res_cf, bus.res_of, bus.res_sf}, {28'd0, e_flags});
        for (int i = 0; i < hold; i++) begin
            bus.req_valid = 1'b1;
            @(posedge clk); #1;
            check({name, "_hold_data"}, {16'd0, bus.res_data}, {16'd0, e_data});
            check({name, "_hold_ready"}, {31'd0, bus.req_ready}, 32'd0);
        end
        bus.req_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        check({name, "_ready_after"}, {31'd0, bus.req_ready}, 32'd1);
        check({name, "_valid_after"}, {31'd0, bus.res_valid}, 32'd0);
    endtask

    int seen;
    initial begin
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_a = 16'd0; bus.req_b = 16'd0;
        bus.req_cin = 1'b0; bus.req_sub = 1'b0; bus.res_ready = 1'b0;

        // Hand-computed pins on the reference itself.
        check("pin_add", {12'd0, model(3'd2, 16'h00FF, 16'h0001, 1'b0, 1'b0)}, {12'd0, 16'h0100, 4'b0000});
        check("pin_sub", {12'd0, model(3'd2, 16'h8000, 16'h0001, 1'b1, 1'b1)}, {12'd0, 16'h7FFF, 4'b0110});
        check("pin_wrap", {12'd0, model(3'd2, 16'hFFFF, 16'h0001, 1'b0, 1'b0)}, {12'd0, 16'h0000, 4'b1100});
        check("pin_shrl", {12'd0, model(3'd5, 16'h0181, 16'h0000, 1'b0, 1'b0)}, {12'd0, 16'h00C0, 4'b0100});
        check("pin_xor", {12'd0, model(3'd4, 16'hAAAA, 16'hFFFF, 1'b0, 1'b0)}, {12'd0, 16'h5555, 4'b0000});
        check("pin_rsv", {12'd0, model(3'd7, 16'h1234, 16'h5678, 1'b1, 1'b1)}, {12'd0, 16'h0000, 4'b1000});
        check("pin_chain", {31'd0, hi_cin(3'd2, 16'h00FF, 16'h0001, 1'b0, 1'b0)}, 32'd1);

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_word", {12'd0, bus.res_data, bus.res_zf, bus.res_cf, bus.res_of, bus.res_sf}, 32'd0);

        // Directed vectors: flags are {zf, cf, of, sf}.
        run_op("add_chain", 3'd2, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 4'b0000, 0);
        run_op("sub_ovf",   3'd2, 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 4'b0110, 0);
        run_op("add_wrap",  3'd2, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 4'b1100, 0);
        run_op("sub_self",  3'd2, 16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 4'b1100, 0);
        run_op("shrl",      3'd5, 16'h0181, 16'h0000, 1'b0, 1'b0, 16'h00C0, 4'b0100, 0);
        run_op("xor",       3'd4, 16'hAAAA, 16'hFFFF, 1'b0, 1'b0, 16'h5555, 4'b0000, 5);
        run_op("and",       3'd3, 16'hF0F0, 16'h3C3C, 1'b1, 1'b1, 16'h3030, 4'b0000, 0);
        run_op("left",      3'd0, 16'h8001, 16'h7777, 1'b0, 1'b0, 16'h8001, 4'b0001, 0);
        run_op("right",     3'd1, 16'h0000, 16'hC350, 1'b0, 1'b1, 16'hC350, 4'b0001, 0);
        run_op("rsv7",      3'd7, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 4'b1000, 0);
        run_op("rsv6",      3'd6, 16'h1357, 16'h2468, 1'b0, 1'b0, 16'h0000, 4'b1000, 2);

        // Reset landing while the high byte is in progress.
        bus.req_valid = 1'b1; bus.req_op = 3'd2; bus.req_a = 16'h4444; bus.req_b = 16'h1111;
        bus.req_cin = 1'b0; bus.req_sub = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("hi_rst_ready", {31'd0, bus.req_ready}, 32'd1);
        check("hi_rst_valid", {31'd0, bus.res_valid}, 32'd0);
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.res_valid) seen++;
        end
        check("hi_rst_ghost", seen, 32'd0);

        // Request coincident with reset must be dropped.
        reset = 1'b1; bus.req_valid = 1'b1; bus.req_op = 3'd4;
        @(posedge clk); #1;
        reset = 1'b0; bus.req_valid = 1'b0;
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        seen = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus.res_valid || !bus.req_ready) seen++;
        end
        check("rst_req_dropped", seen, 32'd0);
        run_op("after_rst", 3'd2, 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 4'b0000, 0);

        // Back-to-back with res_ready held high: one result every four cycles.
        bus.res_ready = 1'b1; bus.req_valid = 1'b1; bus.req_op = 3'd4;
        bus.req_a = 16'h0F0F; bus.req_b = 16'h00FF; bus.req_cin = 1'b0; bus.req_sub = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.res_valid) seen++;
        end
        bus.req_valid = 1'b0; bus.res_ready = 1'b0;
        check("throughput", seen, 32'd3);

        repeat (4) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/o8_wide_seq.md
O8_WIDE_SEQ -- requirements
Module: o8_wide_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports listed in this order: clk in 1 (rising-edge clock); reset in 1 (synchronous, active-high).
REQ-002 The request ports SHALL be: req_valid in 1 (request present); req_ready out 1 (request accepted when high with req_valid); req_op in 3 (0 LEFT, 1 RIGHT, 2 ADD, 3 AND, 4 XOR, 5 SHRL, 6/7 reserved); req_a in 16 (left operand); req_b in 16 (right operand); req_cin in 1 (carry into low byte); req_sub in 1 (invert right operand, ADD only).
REQ-003 The result ports SHALL be: res_valid out 1 (result present); res_ready in 1 (result consumed); res_data out 16; res_zf, res_cf, res_of, res_sf out 1 each (16-bit flags).
REQ-004 The 8-bit ALU drive ports SHALL be: alu_op out 3; alu_left out 8; alu_right out 8; alu_cf_in out 1; alu_not_left, alu_not_right, alu_not_result out 1 each.
REQ-005 The 8-bit ALU return ports SHALL be: alu_result in 8 (combinational ALU result); alu_cf_out in 1 (ALU carry out).

Function
REQ-006 FSM states SHALL be IDLE, LO, HI, DONE; req_ready = (state==IDLE); res_valid = (state==DONE).
REQ-007 IDLE with req_valid: the block SHALL register op/a/b/cin/sub and go to LO; acceptance cycle N; state LO at N+1, HI at N+2, DONE (res_valid=1) from N+3.
REQ-008 LO: alu_op=req_op; alu_left=a[7:0]; alu_right=b[7:0]; alu_cf_in=cin; alu_not_right=sub when op==ADD, else 0.
REQ-009 LO edge: the block SHALL capture alu_result to lo_byte and alu_cf_out to a chain-carry register.
REQ-010 HI: alu_left=a[15:8]; alu_right=b[15:8]; alu_cf_in=chain carry; other controls as in LO.
REQ-011 HI edge: the block SHALL capture alu_result to hi_byte and alu_cf_out to hi_carry.
REQ-012 alu_not_left and alu_not_result SHALL be 0 in every state; all ALU drive outputs SHALL be 0 in IDLE and DONE.
REQ-013 SHRL: res_data = {hi_byte, lo_byte | (a[8]<<7)}, i.e. a logical 16-bit shift right by 1.
REQ-014 Ops 6/7: accepted with normal latency; the ALU is driven with op 0; res_data=0x0000, res_zf=1, other flags 0.
REQ-015 res_data SHALL be {hi_byte, lo_byte}, except as given in REQ-013 and REQ-014.
REQ-016 res_zf SHALL be (res_data==0).
REQ-017 res_sf SHALL be res_data[15].
REQ-018 res_cf SHALL be: hi_carry for ADD; a[0] for SHRL; 0 otherwise.
REQ-019 res_of SHALL be computed locally, for ADD only: b_eff = sub ? ~b : b; of = (a[15]==b_eff[15]) && (res_data[15]!=a[15]); 0 for other ops.
REQ-020 DONE: res_data and flags SHALL hold stable until res_valid&&res_ready; on that edge state goes to IDLE, and req_ready rises the following cycle.
REQ-021 Request inputs SHALL be ignored outside IDLE; throughput is one operation per 4 cycles when res_ready is held high.

Reset
REQ-022 On a clk edge with reset=1, state SHALL become IDLE and all captured bytes, carries and registered request fields SHALL clear to 0, regardless of current state.
REQ-023 After reset: req_ready=1, res_valid=0, res_data=0x0000, all flags 0 (res_zf from idle registers is masked to 0 outside DONE).
REQ-024 A request presented in the same cycle as reset SHALL NOT be accepted.
REQ-025 An operation in flight at reset SHALL be discarded and never produce res_valid.

Verification
REQ-026 ADD a=0x00FF b=0x0001 cin=0 sub=0 -> res_valid at N+3, res_data=0x0100, cf=0 zf=0 of=0 sf=0; alu_cf_in=1 during HI.
REQ-027 ADD sub=1 cin=1 a=0x8000 b=0x0001 -> 0x7FFF, cf=1 of=1 sf=0 zf=0; ADD a=0xFFFF b=0x0001 cin=0 -> 0x0000, zf=1 cf=1 of=0.
REQ-028 SHRL a=0x0181 -> 0x00C0, cf=1; XOR a=0xAAAA b=0xFFFF -> 0x5555, cf=0 of=0.
REQ-029 op=7 with any operands -> 0x0000, zf=1, latency 3.
REQ-030 res_ready low 5 cycles in DONE -> res_valid, res_data and flags stable, req_ready=0 throughout, new req_valid ignored; res_ready high -> IDLE next cycle.
REQ-031 Reset asserted while in HI -> next cycle req_ready=1 and res_valid=0; no result ever appears for that operation; the next request completes normally.
